// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_t;

  // Bits needed to index 'value' entries (ceil(log2(value))).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; accepts a push while full if a pop happens
// in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    w_ptr_diff;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_ptr_diff = r_wr_ptr ^ r_rd_ptr;
  assign o_empty    = (w_ptr_diff == '0);
  assign o_full     = (w_ptr_diff == {1'b1, {AW{1'b0}}});

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  // Forced to zero when empty so the head reads as zero out of reset.
  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small receive FIFO, with sticky framing/overrun flags.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote at every sample point.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rdy,
  output logic                 full,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr
);

  localparam int unsigned CW = clog2(CLKS_PER_BIT);
  localparam int unsigned BW = clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  rx_state_t r_state;
  rx_state_t w_state_d;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic                 r_rx_prev;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_rx_fall;
  logic w_bit;
  logic w_tick_half;
  logic w_tick_bit;
  logic w_cnt_clr;
  logic w_shift;
  logic w_push_req;
  logic w_ferr_set;
  logic w_ovr_set;
  logic w_pop;
  logic w_empty;
  logic w_full;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_s;

`ifdef UART_RX_MAJORITY_EN
  logic r_rx_prev2;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_rx_prev2 <= 1'b1;
    else        r_rx_prev2 <= r_rx_prev;
  end

  // The decision edge stays put; the two earlier samples are taken from history.
  assign w_bit = (r_rx_s & r_rx_prev) | (r_rx_s & r_rx_prev2) | (r_rx_prev & r_rx_prev2);
`else
  assign w_bit = r_rx_s;
`endif

  assign w_tick_half = (r_cnt == HALF_LAST);
  assign w_tick_bit  = (r_cnt == BIT_LAST);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:     if (w_rx_fall) w_state_d = StStart;
      StStart:    if (w_tick_half) w_state_d = w_bit ? StIdle : StData;
      StData:     if (w_tick_bit && (r_bit_cnt == IDX_LAST)) w_state_d = StStop;
      StStop:     if (w_tick_bit) w_state_d = w_bit ? StIdle : StWaitIdle;
      StWaitIdle: if (r_rx_s) w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_clr  = 1'b0;
    w_shift    = 1'b0;
    w_push_req = 1'b0;
    w_ferr_set = 1'b0;
    unique case (r_state)
      StIdle:  w_cnt_clr = 1'b1;
      StStart: w_cnt_clr = w_tick_half;
      StData: begin
        w_cnt_clr = w_tick_bit;
        w_shift   = w_tick_bit;
      end
      StStop: begin
        w_push_req = w_tick_bit & w_bit;
        w_ferr_set = w_tick_bit & ~w_bit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (w_cnt_clr) r_cnt <= '0;
      else           r_cnt <= r_cnt + CW'(1);

      if (r_state != StData) r_bit_cnt <= '0;
      else if (w_shift)      r_bit_cnt <= r_bit_cnt + BW'(1);

      // LSB arrives first, so each new bit enters at the top.
      if (w_shift) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
    end
  end

  assign w_pop     = rd_en & ~w_empty;
  assign w_ovr_set = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_ferr_set)   r_frame_err <= 1'b1;
      else if (err_clr) r_frame_err <= 1'b0;

      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (err_clr) r_overrun <= 1'b0;
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .rst_n   (rst_n),
    .i_push  (w_push_req),
    .i_wdata (r_shift),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (dout)
  );

  assign rdy       = ~w_empty;
  assign full      = w_full;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames driven on negedges, FIFO output checked
// against a queue of expected bytes.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clock   = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx      = 1'b1;
  logic       rd_en   = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] dout;
  logic       rdy;
  logic       full;
  logic       frame_err;
  logic       overrun;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] q[$];

  always #5 clock = ~clock;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .rx        (rx),
    .rd_en     (rd_en),
    .dout      (dout),
    .rdy       (rdy),
    .full      (full),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      rx      = 1'b1;
      rd_en   = 1'b0;
      err_clr = 1'b0;
    end
  endtask

  // Drives n_cyc cycles of an 8N1 frame. Pops the FIFO in cycle pop_at (checking the head),
  // forces rx low in cycle glitch_at, and reports the first cycle rdy was seen high.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_at,
                            input int glitch_at, input int n_cyc, output int rdy_at);
    logic       lvl;
    logic [7:0] bb;
    int         idx;
    bb     = b;
    rdy_at = -1;
    for (int j = 0; j < n_cyc; j++) begin
      @(negedge clock);
      if (rdy_at < 0 && rdy === 1'b1) rdy_at = j;
      idx = (j - CPB) / CPB;
      if (j < CPB)           lvl = 1'b0;
      else if (j < 9 * CPB)  lvl = bb[idx[2:0]];
      else                   lvl = stop_bit;
      if (j == glitch_at) lvl = 1'b0;
      rx = lvl;
      if (j == pop_at) begin
        checks++;
        if (q.size() == 0 || dout !== q[0] || rdy !== 1'b1) begin
          failures++;
          $display("FAIL pop_in_frame: dout=%h rdy=%b, required head dout=%h rdy=1",
                   dout, rdy, (q.size() > 0) ? q[0] : 8'hxx);
        end
        if (q.size() > 0) void'(q.pop_front());
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
    end
  endtask

  task automatic read_byte(input string name);
    logic [7:0] exp_b;
    int         t;
    t = 0;
    while (rdy !== 1'b1 && t < 400) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL %s: dout=%h rdy=%b but no byte was expected", name, dout, rdy);
    end else begin
      exp_b = q.pop_front();
      if (rdy !== 1'b1 || dout !== exp_b) begin
        failures++;
        $display("FAIL %s: rdy=%b dout=%h, required rdy=1 dout=%h", name, rdy, dout, exp_b);
      end
    end
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic actual, input logic required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s: got %b, required %b", name, actual, required);
    end
  endtask

  task automatic test_reset;
    #1;
    check_bit("reset_rdy", rdy, 1'b0);
    check_bit("reset_full", full, 1'b0);
    check_bit("reset_frame_err", frame_err, 1'b0);
    check_bit("reset_overrun", overrun, 1'b0);
    checks++;
    if (dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_dout: got %h, required 00", dout);
    end
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    idle(20);
  endtask

  task automatic test_single;
    int rdy_at;
    q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, -1, FRAME, rdy_at);
    checks++;
    if (rdy_at != 155) begin
      failures++;
      $display("FAIL single_latency: rdy first seen at cycle %0d, required 155", rdy_at);
    end
    check_bit("single_frame_err", frame_err, 1'b0);
    check_bit("single_overrun", overrun, 1'b0);
    read_byte("single_dout");
    check_bit("single_rdy_after_pop", rdy, 1'b0);
    idle(8);
  endtask

  task automatic test_back_to_back;
    int rdy_at;
    for (int i = 0; i < 4; i++) begin
      q.push_back(8'(i));
      send_frame(8'(i), 1'b1, -1, -1, FRAME, rdy_at);
      if (i == 2) check_bit("b2b_not_full_at_3", full, 1'b0);
    end
    check_bit("b2b_full_at_4", full, 1'b1);
    send_frame(8'hFF, 1'b1, -1, -1, FRAME, rdy_at);
    check_bit("b2b_overrun", overrun, 1'b1);
    check_bit("b2b_still_full", full, 1'b1);
    for (int i = 0; i < 4; i++) read_byte("b2b_drain");
    check_bit("b2b_empty_after_drain", rdy, 1'b0);
    @(negedge clock);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    check_bit("b2b_overrun_cleared", overrun, 1'b0);
    idle(8);
  endtask

  task automatic test_framing;
    int rdy_at;
    send_frame(8'h3C, 1'b0, -1, -1, FRAME, rdy_at);
    check_bit("ferr_set", frame_err, 1'b1);
    check_bit("ferr_no_push", rdy, 1'b0);
    @(negedge clock);
    rx      = 1'b0;
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    check_bit("ferr_cleared_in_break", frame_err, 1'b0);
    repeat (40 * CPB) @(negedge clock);
    check_bit("ferr_break_single_error", frame_err, 1'b0);
    check_bit("ferr_break_no_push", rdy, 1'b0);
    idle(32);
    q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, -1, FRAME, rdy_at);
    read_byte("ferr_recover_dout");
    check_bit("ferr_recover_flag", frame_err, 1'b0);
    idle(8);
  endtask

  task automatic test_glitch;
    int rdy_at;
    repeat (4) begin
      @(negedge clock);
      rx = 1'b0;
    end
    idle(60);
    check_bit("glitch_no_push", rdy, 1'b0);
    check_bit("glitch_no_ferr", frame_err, 1'b0);
    check_bit("glitch_no_overrun", overrun, 1'b0);
    q.push_back(8'h42);
    send_frame(8'h42, 1'b1, -1, -1, FRAME, rdy_at);
    read_byte("glitch_then_frame");
    idle(8);
  endtask

  task automatic test_full_pop;
    int rdy_at;
    for (int i = 0; i < 4; i++) begin
      q.push_back(8'h10 + 8'(i));
      send_frame(8'h10 + 8'(i), 1'b1, -1, -1, FRAME, rdy_at);
    end
    check_bit("fullpop_full_before", full, 1'b1);
    q.push_back(8'h77);
    // Cycle 154 spans the stop-bit sample edge.
    send_frame(8'h77, 1'b1, 154, -1, FRAME, rdy_at);
    idle(1);
    check_bit("fullpop_no_overrun", overrun, 1'b0);
    check_bit("fullpop_still_full", full, 1'b1);
    for (int i = 0; i < 4; i++) read_byte("fullpop_drain");
    check_bit("fullpop_empty", rdy, 1'b0);
    idle(8);
  endtask

  task automatic test_reset_mid;
    int rdy_at;
    send_frame(8'h00, 1'b0, -1, -1, FRAME, rdy_at);
    idle(16);
    q.push_back(8'h99);
    send_frame(8'h99, 1'b1, -1, -1, FRAME, rdy_at);
    check_bit("rstmid_pre_ferr", frame_err, 1'b1);
    check_bit("rstmid_pre_rdy", rdy, 1'b1);
    send_frame(8'h5A, 1'b1, -1, -1, 4 * CPB + 5, rdy_at);
    @(negedge clock);
    rst_n = 1'b0;
    rx    = 1'b1;
    q.delete();
    #1;
    check_bit("rstmid_rdy", rdy, 1'b0);
    check_bit("rstmid_full", full, 1'b0);
    check_bit("rstmid_ferr", frame_err, 1'b0);
    check_bit("rstmid_overrun", overrun, 1'b0);
    checks++;
    if (dout !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_dout: got %h, required 00", dout);
    end
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    idle(20);
    q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1, -1, FRAME, rdy_at);
    read_byte("rstmid_after_release");
    idle(8);
  endtask

  task automatic test_majority;
    int rdy_at;
`ifdef UART_RX_MAJORITY_EN
    q.push_back(8'hFF);
`else
    q.push_back(8'hF7);
`endif
    // One-cycle dip at the centre of data bit 3.
    send_frame(8'hFF, 1'b1, -1, 4 * CPB + CPB / 2, FRAME, rdy_at);
    read_byte("majority_glitch_bit3");
    idle(8);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_full_pop();
    test_reset_mid();
    test_majority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Standalone UART receiver: the receive end of the team's 8N1 serial link, the counterpart to the UART transmitter driving the `tx` line.
- Samples an asynchronous serial line, recovers 8N1 frames (LSB first), pushes good bytes into a small receive FIFO.
- Flags framing errors and overruns.
- Sits between the pin and the host-side consumer; replaces single-byte rdy/rdy_clr buffering with a multi-entry queue.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per bit period; even, >= 8.
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, >= 2.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, asynchronous, idle high.
- rd_en  in  1  pop FIFO head; ignored when rdy=0.
- dout  out  8  FIFO head byte; valid while rdy=1.
- rdy  out  1  FIFO non-empty.
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- frame_err  out  1  sticky: stop bit sampled low.
- overrun  out  1  sticky: good byte dropped because FIFO full.
- err_clr  in  1  clears frame_err and overrun.

Behaviour:
- Reset values: dout=0, rdy=0, full=0, frame_err=0, overrun=0; FSM=IDLE; synchronizer flops=1; FIFO pointers=0.
- Reset mid-frame: partial byte discarded; FIFO contents lost.
- Input path: rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: rx_s falling edge (1 then 0) -> START; bit counter cleared.
- START: after CLKS_PER_BIT/2 cycles, sample rx_s.
  - 0 -> DATA, bit counter restarted.
  - 1 -> glitch; return to IDLE, no flag.
- DATA: sample every CLKS_PER_BIT cycles; shift into bit 7, so LSB arrives first. After 8 samples -> STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - 1 -> push byte; return to IDLE.
  - 0 -> set frame_err, discard byte -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then IDLE. A break condition therefore produces exactly one frame_err, not repeated frames.
- Push on good stop bit, FIFO full, no pop that cycle: byte dropped, overrun set.
- Latency: rdy rises the cycle after the stop-bit sample edge.
- FIFO:
  - dout always reflects the head.
  - rd_en with rdy=1 advances the head; new dout/rdy visible next cycle.
  - Simultaneous push and pop while full: both succeed, no overrun, full stays 1.
  - Simultaneous push and pop while holding 1 entry: rdy stays 1, dout shows the pushed byte next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full and empty are decided from the MSB difference.
- err_clr: clears both sticky flags next cycle. If a set event occurs in the same cycle, set wins.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every sample point (start, data, stop) takes a 2-of-3 majority of rx_s at mid-1, mid, mid+1 cycles. Decision timing and the latency above are unchanged; the vote resolves at mid+1.
- Undefined: a single rx_s sample at mid-bit.

Decomposition:
- Package uart_pkg: FSM state enum (rx_state_t), DATA_BITS=8 constant, ptr-width function clog2.
- One sub-module, uart_sync_fifo (parameterised by width and depth; push, pop, full, empty, head). The receiver instantiates it.
- The bit-timing FSM stays in uart_rx_fifo.

Test Plan:
- Single frame 0xA5, CLKS_PER_BIT=16, clean line -> rdy rises ~155 cycles after start edge; dout=0xA5; no flags. Pulse rd_en -> rdy=0 next cycle.
- Back-to-back frames 0x00..0x03, no reads -> full=1 after 4th frame, bytes in order. 5th frame 0xFF -> overrun=1, 0xFF absent. Drain gives 00,01,02,03.
- Frame 0x3C with stop bit forced low, rx held low 40 bit times -> exactly one frame_err, no push. rx returns high then frame 0x11 -> dout=0x11. err_clr -> frame_err=0.
- Glitch: rx low 4 cycles then high -> FSM returns to IDLE, no push, no flags.
- FIFO full plus rd_en in the exact stop-sample cycle of a 5th frame 0x77 -> no overrun; 0x77 at tail.
- rst_n asserted mid-DATA of frame 0x5A -> all outputs at reset values. Next full frame 0x5A after release -> received correctly.
- UART_RX_MAJORITY_EN defined: 1-cycle low glitch at mid-bit of a '1' data bit in 0xFF -> dout=0xFF. Undefined -> dout shows that bit as 0.
